// File: rtl/kugelblitz_patch_sched.sv
// Per-port byte-patch rule scheduler: shadow/active rule tables with frame-boundary commits.
// Optional statistics counters are built when KUGELBLITZ_PATCH_STATS_EN is defined.
module kugelblitz_patch_sched #(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int RULE_COUNT   = 4,
    parameter int OFFSET_WIDTH = 16,
    parameter int IDX_WIDTH    = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]    cfg_wr_idx,
    input  logic [OFFSET_WIDTH-1:0] cfg_wr_offset,
    input  logic [7:0]              cfg_wr_data,
    input  logic                    cfg_wr_enable,
    input  logic                    cfg_commit,
    output logic                    cfg_busy,
    input  logic                    mon_tvalid,
    input  logic                    mon_tready,
    input  logic                    mon_tlast,
    output logic                    kg_address_valid,
    output logic [5:0]              kg_address,
    output logic [7:0]              kg_data,
    output logic [31:0]             stat_patch_count,
    output logic [15:0]             stat_collisions
);
    localparam int LANE_BITS = $clog2(KEEP_WIDTH);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t state, state_n;
    logic [OFFSET_WIDTH-LANE_BITS-1:0] beat_idx, beat_idx_n;
    logic pending, pending_n;
    logic xfer, copy;

    logic [OFFSET_WIDTH-1:0] sh_off [RULE_COUNT];
    logic [OFFSET_WIDTH-1:0] sh_off_n [RULE_COUNT];
    logic [OFFSET_WIDTH-1:0] act_off [RULE_COUNT];
    logic [OFFSET_WIDTH-1:0] act_off_n [RULE_COUNT];
    logic [7:0] sh_dat [RULE_COUNT];
    logic [7:0] sh_dat_n [RULE_COUNT];
    logic [7:0] act_dat [RULE_COUNT];
    logic [7:0] act_dat_n [RULE_COUNT];
    logic [RULE_COUNT-1:0] sh_en, sh_en_n, act_en, act_en_n;

    logic kg_valid_n;
    logic [LANE_BITS-1:0] kg_addr_n;
    logic [7:0] kg_data_n;

    assign xfer = mon_tvalid & mon_tready;
    // A commit lands at a frame boundary: idle with nothing moving, or on the closing beat.
    assign copy = (cfg_commit | pending) & ((state == IDLE & ~xfer) | (xfer & mon_tlast));
    assign pending_n = (cfg_commit | pending) & ~copy;
    assign cfg_busy = pending;

    always_comb begin
        state_n    = state;
        beat_idx_n = beat_idx;
        if (xfer) begin
            if (mon_tlast) begin
                state_n    = IDLE;
                beat_idx_n = '0;
            end else begin
                state_n = ACTIVE;
                if (beat_idx != '1) begin
                    beat_idx_n = beat_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sh_off_n = sh_off;
        sh_dat_n = sh_dat;
        sh_en_n  = sh_en;
        if (cfg_wr_en && (int'(cfg_wr_idx) < RULE_COUNT)) begin
            sh_off_n[cfg_wr_idx] = cfg_wr_offset;
            sh_dat_n[cfg_wr_idx] = cfg_wr_data;
            sh_en_n[cfg_wr_idx]  = cfg_wr_enable;
        end
        act_off_n = copy ? sh_off_n : act_off;
        act_dat_n = copy ? sh_dat_n : act_dat;
        act_en_n  = copy ? sh_en_n  : act_en;
    end

    // Match against next-cycle index and table so the registered kg_* line up with beat_idx.
    always_comb begin
        kg_valid_n = 1'b0;
        kg_addr_n  = '0;
        kg_data_n  = '0;
        for (int r = RULE_COUNT - 1; r >= 0; r--) begin
            if (act_en_n[r] && (act_off_n[r][OFFSET_WIDTH-1:LANE_BITS] == beat_idx_n)) begin
                kg_valid_n = 1'b1;
                kg_addr_n  = act_off_n[r][LANE_BITS-1:0];
                kg_data_n  = act_dat_n[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            beat_idx         <= '0;
            pending          <= 1'b0;
            sh_en            <= '0;
            act_en           <= '0;
            kg_address_valid <= 1'b0;
            kg_address       <= '0;
            kg_data          <= '0;
            for (int r = 0; r < RULE_COUNT; r++) begin
                sh_off[r]  <= '0;
                sh_dat[r]  <= '0;
                act_off[r] <= '0;
                act_dat[r] <= '0;
            end
        end else begin
            state            <= state_n;
            beat_idx         <= beat_idx_n;
            pending          <= pending_n;
            sh_off           <= sh_off_n;
            sh_dat           <= sh_dat_n;
            sh_en            <= sh_en_n;
            act_off          <= act_off_n;
            act_dat          <= act_dat_n;
            act_en           <= act_en_n;
            kg_address_valid <= kg_valid_n;
            kg_address       <= kg_addr_n;
            kg_data          <= kg_data_n;
        end
    end

`ifdef KUGELBLITZ_PATCH_STATS_EN
    logic hit_seen, multi_hit;
    logic [31:0] patch_q;
    logic [15:0] coll_q;

    always_comb begin
        hit_seen  = 1'b0;
        multi_hit = 1'b0;
        for (int r = 0; r < RULE_COUNT; r++) begin
            if (act_en[r] && (act_off[r][OFFSET_WIDTH-1:LANE_BITS] == beat_idx)) begin
                if (hit_seen) begin
                    multi_hit = 1'b1;
                end
                hit_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            patch_q <= '0;
            coll_q  <= '0;
        end else begin
            if (xfer && kg_address_valid && (patch_q != '1)) begin
                patch_q <= patch_q + 1'b1;
            end
            if (xfer && multi_hit && (coll_q != '1)) begin
                coll_q <= coll_q + 1'b1;
            end
        end
    end

    assign stat_patch_count = patch_q;
    assign stat_collisions  = coll_q;
`else
    assign stat_patch_count = '0;
    assign stat_collisions  = '0;
`endif

endmodule
